// File: rtl/dice_roller.sv
// Electronic dice: two-flop synchronised, debounced buttons, a tumbling die pair and a roll FSM.
// Ports: CLK/ResetN, BtnRoll/BtnNew raw in, Roll/Win/Lose ctl in; Rb, Reset, Sum, Die1/2, SumValid, RollCount out.
// DICE_ROLLCOUNT_EN: builds the saturating RollCount register; otherwise RollCount is tied to 0.
module dice_roller #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       ResetN,
  input  logic       BtnRoll,
  input  logic       BtnNew,
  input  logic       Roll,
  input  logic       Win,
  input  logic       Lose,
  output logic       Rb,
  output logic       Reset,
  output logic [3:0] Sum,
  output logic [2:0] Die1,
  output logic [2:0] Die2,
  output logic       SumValid,
  output logic [7:0] RollCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  // index 0 = roll button, index 1 = new-game button
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] deb_q, deb_d;
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];
  logic       new_prev_q;

  state_t     state_q, state_d;
  logic [2:0] die1_q, die1_d;
  logic [2:0] die2_q, die2_d;
  logic [3:0] sum_q, sum_d;
  logic       valid_q;
  logic       reset_q, reset_d;

  // A level flips only after DEB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      new_prev_q <= 1'b0;
    end else begin
      sync1_q    <= {BtnNew, BtnRoll};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      new_prev_q <= deb_q[1];
    end
  end

  // Reset pulses the cycle after the debounced new-game edge cycle.
  assign reset_d = deb_q[1] & ~new_prev_q & (Win | Lose);

  // Die2 steps only when Die1 wraps, giving a 36-cycle sequence.
  always_comb begin
    die1_d = die1_q;
    die2_d = die2_q;
    if (Roll) begin
      if (die1_q == 3'd6) begin
        die1_d = 3'd1;
        die2_d = (die2_q == 3'd6) ? 3'd1 : die2_q + 3'd1;
      end else begin
        die1_d = die1_q + 3'd1;
      end
    end
    sum_d = {1'b0, die1_d} + {1'b0, die2_d};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Roll)  state_d = ROLLING;
      ROLLING: if (!Roll) state_d = SETTLE;
      SETTLE:  state_d = Roll ? ROLLING : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      die1_q  <= 3'd1;
      die2_q  <= 3'd1;
      sum_q   <= 4'd2;
      valid_q <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      state_q <= state_d;
      die1_q  <= die1_d;
      die2_q  <= die2_d;
      sum_q   <= sum_d;
      valid_q <= (state_d == SETTLE);
      reset_q <= reset_d;
    end
  end

`ifdef DICE_ROLLCOUNT_EN
  logic [7:0] rc_q;
  logic       settle_enter;

  assign settle_enter = (state_q == ROLLING) && (state_d == SETTLE);

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      rc_q <= '0;
    end else if (settle_enter && rc_q != 8'hFF) begin
      rc_q <= rc_q + 8'd1;
    end
  end

  assign RollCount = rc_q;
`else
  assign RollCount = '0;
`endif

  assign Rb       = deb_q[0];
  assign Reset    = reset_q;
  assign Die1     = die1_q;
  assign Die2     = die2_q;
  assign Sum      = sum_q;
  assign SumValid = valid_q;

endmodule

// File: tb/tb_dice_roller.sv
// Testbench for dice_roller: roll table, button debounce/new-game sequences,
// async reset mid-roll and a randomized roll stream against an arithmetic model.
module tb_dice_roller;

  logic       CLK;
  logic       ResetN;
  logic       BtnRoll;
  logic       BtnNew;
  logic       Roll;
  logic       Win;
  logic       Lose;
  logic       Rb;
  logic       Reset;
  logic [3:0] Sum;
  logic [2:0] Die1;
  logic [2:0] Die2;
  logic       SumValid;
  logic [7:0] RollCount;

  int errors = 0;
  int checks = 0;

  dice_roller #(.DEB_CYCLES(4)) dut (
    .CLK       (CLK),
    .ResetN    (ResetN),
    .BtnRoll   (BtnRoll),
    .BtnNew    (BtnNew),
    .Roll      (Roll),
    .Win       (Win),
    .Lose      (Lose),
    .Rb        (Rb),
    .Reset     (Reset),
    .Sum       (Sum),
    .Die1      (Die1),
    .Die2      (Die2),
    .SumValid  (SumValid),
    .RollCount (RollCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int n;
    int d1;
    int d2;
    int sum;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    ResetN  = 1'b0;
    BtnRoll = 1'b0;
    BtnNew  = 1'b0;
    Roll    = 1'b0;
    Win     = 1'b0;
    Lose    = 1'b0;
    tick();
    tick();
    ResetN = 1'b1;
  endtask

  function automatic int exp_rc(input int falls);
`ifdef DICE_ROLLCOUNT_EN
    return (falls > 255) ? 255 : falls;
`else
    return 0 * falls;
`endif
  endfunction

  int hi_at;
  int hi_cnt;
  int n;
  int prev;
  int falls;
  int r;

  initial begin
    tbl[0] = '{0, 1, 1, 2};
    tbl[1] = '{1, 2, 1, 3};
    tbl[2] = '{3, 4, 1, 5};
    tbl[3] = '{6, 1, 2, 3};
    tbl[4] = '{7, 2, 2, 4};
    tbl[5] = '{35, 6, 6, 12};
    tbl[6] = '{36, 1, 1, 2};
    tbl[7] = '{37, 2, 1, 3};

    do_reset();
    chk("rst_die1", int'(Die1), 1);
    chk("rst_die2", int'(Die2), 1);
    chk("rst_sum", int'(Sum), 2);
    chk("rst_rb", int'(Rb), 0);
    chk("rst_reset", int'(Reset), 0);
    chk("rst_valid", int'(SumValid), 0);
    chk("rst_rc", int'(RollCount), 0);

    // roll table: n rolling cycles, then settle and idle
    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int k = 0; k < tbl[i].n; k++) begin
        Roll = 1'b1;
        tick();
      end
      Roll = 1'b0;
      chk("tbl_die1", int'(Die1), tbl[i].d1);
      chk("tbl_die2", int'(Die2), tbl[i].d2);
      chk("tbl_sum", int'(Sum), tbl[i].sum);
      chk("tbl_valid_pre", int'(SumValid), 0);
      tick();
      chk("tbl_valid", int'(SumValid), (tbl[i].n > 0) ? 1 : 0);
      chk("tbl_rc", int'(RollCount), exp_rc((tbl[i].n > 0) ? 1 : 0));
      chk("tbl_sum_hold", int'(Sum), tbl[i].sum);
      tick();
      chk("tbl_valid_end", int'(SumValid), 0);
      chk("tbl_sum_hold2", int'(Sum), tbl[i].sum);
    end

    // bouncing roll button: 1,0,1 then stable
    do_reset();
    BtnRoll = 1'b1;
    tick();
    BtnRoll = 1'b0;
    tick();
    BtnRoll = 1'b1;
    hi_at = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (Rb && hi_at < 0) hi_at = k;
    end
    chk("deb_rb_edge", hi_at, 6);
    chk("deb_rb_level", int'(Rb), 1);

    // new-game press while won, with rolling in progress
    do_reset();
    Win    = 1'b1;
    Roll   = 1'b1;
    BtnNew = 1'b1;
    hi_at  = -1;
    hi_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (Reset) begin
        hi_cnt++;
        if (hi_at < 0) hi_at = k;
      end
    end
    chk("newgame_pulse_at", hi_at, 7);
    chk("newgame_pulse_len", hi_cnt, 1);

    // same press with no win/lose: ignored
    do_reset();
    BtnNew = 1'b1;
    hi_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (Reset) hi_cnt++;
    end
    chk("newgame_ignored", hi_cnt, 0);

    // asynchronous reset mid-roll with Die1=4
    do_reset();
    Roll = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_die1_before", int'(Die1), 4);
    #2;
    ResetN = 1'b0;
    #1;
    chk("async_die1", int'(Die1), 1);
    chk("async_sum", int'(Sum), 2);
    chk("async_valid", int'(SumValid), 0);
    chk("async_rc", int'(RollCount), 0);
    Roll = 1'b0;
    tick();
    ResetN = 1'b1;
    tick();
    chk("post_rst_valid", int'(SumValid), 0);
    chk("post_rst_rc", int'(RollCount), 0);
    chk("post_rst_die1", int'(Die1), 1);

    // random roll stream vs arithmetic model
    do_reset();
    n     = 0;
    prev  = 0;
    falls = 0;
    for (int k = 0; k < 400; k++) begin
      r    = int'($urandom_range(0, 1));
      Roll = r[0];
      Win  = 1'($urandom_range(0, 1));
      Lose = 1'($urandom_range(0, 1));
      tick();
      if (r == 1) n++;
      if (r == 0 && prev == 1) falls++;
      chk("rnd_die1", int'(Die1), n % 6 + 1);
      chk("rnd_die2", int'(Die2), (n / 6) % 6 + 1);
      chk("rnd_sum", int'(Sum), n % 6 + (n / 6) % 6 + 2);
      chk("rnd_valid", int'(SumValid), (r == 0 && prev == 1) ? 1 : 0);
      chk("rnd_rc", int'(RollCount), exp_rc(falls));
      chk("rnd_reset", int'(Reset), 0);
      prev = r;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 SHALL have parameter: DEB_CYCLES, 4, consecutive stable cycles required before a debounced button level changes (range 1..255).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: ResetN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: BtnRoll  input  1  raw roll pushbutton, asynchronous to CLK, 1 = pressed.
REQ-005 SHALL have port: BtnNew  input  1  raw new-game pushbutton, asynchronous to CLK, 1 = pressed.
REQ-006 SHALL have port: Roll  input  1  from game controller; 1 = dice must tumble.
REQ-007 SHALL have port: Win  input  1  from game controller; game won.
REQ-008 SHALL have port: Lose  input  1  from game controller; game lost.
REQ-009 SHALL have port: Rb  output  1  debounced roll-button level, to game controller.
REQ-010 SHALL have port: Reset  output  1  one-cycle game-reset pulse, to game controller.
REQ-011 SHALL have port: Sum  output  4  registered Die1+Die2, range 2..12.
REQ-012 SHALL have port: Die1, Die2  output  3 each  registered die faces, range 1..6.
REQ-013 SHALL have port: SumValid  output  1  1 while Sum is settled after a completed roll.
REQ-014 SHALL have port: RollCount  output  8  number of completed rolls.

Function
REQ-015 SHALL pass BtnRoll and BtnNew each through a 2-flop synchronizer before any other use.
REQ-016 SHALL change each debounced level only after its synchronized input differs from it for DEB_CYCLES consecutive cycles; any agreeing cycle clears that debounce counter.
REQ-017 SHALL drive Rb directly from the debounced BtnRoll level (latency 2+DEB_CYCLES cycles from a clean raw edge).
REQ-018 SHALL, in every cycle with Roll=1, advance Die1 1->2->...->6->1; when Die1 wraps 6->1, Die2 SHALL advance the same way in the same cycle (36-cycle period).
REQ-019 SHALL hold Die1, Die2 and Sum unchanged in every cycle with Roll=0.
REQ-020 SHALL update Sum in the same edge as the dice, always equal to the registered Die1+Die2 (no extra latency, never outside 2..12).
REQ-021 SHALL implement FSM IDLE/ROLLING/SETTLE: IDLE->ROLLING on Roll=1; ROLLING->SETTLE on Roll=0; SETTLE->ROLLING on Roll=1, else SETTLE->IDLE.
REQ-022 SHALL assert SumValid registered, high exactly while the FSM is in SETTLE (one cycle per completed roll).
REQ-023 SHALL increment RollCount on each ROLLING->SETTLE transition and saturate at 255.
REQ-024 SHALL pulse Reset high for exactly one cycle on the cycle after a debounced BtnNew rising edge, only if Win=1 or Lose=1 on that edge cycle; otherwise the press is ignored.
REQ-025 SHALL generate Reset independently of Roll/FSM activity; a simultaneous Roll does not suppress it.

Reset
REQ-026 SHALL, while ResetN=0, immediately force: Die1=1, Die2=1, Sum=2, Rb=0, Reset=0, SumValid=0, RollCount=0, FSM=IDLE, synchronizers and debounced levels 0, debounce counters 0.
REQ-027 SHALL, on ResetN asserted mid-roll, abort the roll without incrementing RollCount; after release, resume from the reset values.

Configuration
REQ-028 SHALL compile the roll counter only when DICE_ROLLCOUNT_EN is defined; without it RollCount SHALL be constant 0 and no counter register exists.

Verification
REQ-029 SHALL cover: reset, then Roll=1 for 7 cycles -> Die1=2, Die2=2, Sum=4.
REQ-030 SHALL cover: from reset, Roll=1 for 35 cycles -> Die1=6, Die2=6, Sum=12; one more cycle -> Die1=1, Die2=1, Sum=2.
REQ-031 SHALL cover: BtnRoll bouncing 1,0,1 at one-cycle intervals then stable 1 (DEB_CYCLES=4) -> Rb rises exactly 2+4 cycles after the final stable edge, never earlier.
REQ-032 SHALL cover: Roll 1 for 3 cycles then 0 -> SumValid high for exactly one cycle, RollCount=1 (0 without DICE_ROLLCOUNT_EN), Sum held while Roll=0.
REQ-033 SHALL cover: debounced BtnNew rise with Win=1 -> one-cycle Reset pulse; repeat with Win=Lose=0 -> no pulse.
REQ-034 SHALL cover: ResetN low during Roll=1 with Die1=4 -> Die1=1, Sum=2, SumValid=0, RollCount unchanged at 0.
